// File: rtl/spi_pkg.sv
// spi_pkg: shared state encodings, protocol constants and address-advance helper for SPI register blocks.
// SPI_REG_CTRL_AUTOINC_EN selects auto-incrementing burst addresses; otherwise the address stays fixed.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD_REQ,
        ST_WR_REQ,
        ST_DATA,
        ST_DRAIN
    } state_t;

    localparam logic [7:0] SPI_ERR_BYTE  = 8'hEE;
    localparam logic [7:0] SPI_IDLE_BYTE = 8'h00;
    localparam int         RW_BIT        = 7;

    function automatic logic [6:0] next_addr(input logic [6:0] a);
`ifdef SPI_REG_CTRL_AUTOINC_EN
        return a + 7'd1;
`else
        return a;
`endif
    endfunction

endpackage

// File: rtl/spi_ncs_sync.sv
// spi_ncs_sync: 3-stage chip-select synchronizer emitting one-cycle frame start/stop pulses.
module spi_ncs_sync (
    input  logic clk,
    input  logic rst,
    input  logic ncs,
    output logic start,
    output logic stop
);

    logic [2:0] s;
    logic       active;

    always_ff @(posedge clk) begin
        if (rst) begin
            s      <= 3'b111;
            active <= 1'b0;
        end else begin
            s      <= {s[1:0], ncs};
            active <= (s == 3'b000) ? 1'b1 : (&s) ? 1'b0 : active;
        end
    end

    // Edges only: glitches shorter than three samples never reach all-0 or all-1.
    assign start = ~active & (s == 3'b000);
    assign stop  = active & (&s);

endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI byte stream to register bus bridge with burst access, ack timeout and frame abort.
// Optional SPI_REG_CTRL_AUTOINC_EN advances the address per burst byte.
module spi_reg_ctrl
    import spi_pkg::*;
#(
    parameter int DELAY  = 2,
    parameter int ACK_TO = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ncs,
    input  logic       rec_flag,
    input  logic [7:0] rec_data,
    output logic [7:0] send_data,
    output logic       reg_req,
    output logic       reg_wr,
    output logic [6:0] reg_addr,
    output logic [7:0] reg_wdata,
    input  logic [7:0] reg_rdata,
    input  logic       reg_ack,
    output logic       err
);

    if (ACK_TO < 1 || ACK_TO > 255 || DELAY < 0) begin : g_param_check
        $error("spi_reg_ctrl: parameter out of range");
    end

    localparam logic [7:0] ACK_LAST = 8'(ACK_TO - 1);

    state_t     state;
    logic       rec_q;
    logic       ev;
    logic       start;
    logic       stop;
    logic [7:0] cnt;

    spi_ncs_sync u_sync (
        .clk  (clk),
        .rst  (rst),
        .ncs  (ncs),
        .start(start),
        .stop (stop)
    );

    assign ev = rec_flag & ~rec_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            send_data <= SPI_IDLE_BYTE;
            reg_req   <= 1'b0;
            reg_wr    <= 1'b0;
            reg_addr  <= 7'd0;
            reg_wdata <= 8'd0;
            err       <= 1'b0;
            rec_q     <= 1'b0;
            cnt       <= 8'd0;
        end else begin
            rec_q <= rec_flag;
            if (start)
                err <= 1'b0;
            if (stop && state != ST_IDLE) begin
                state     <= ST_IDLE;
                reg_req   <= 1'b0;
                send_data <= SPI_IDLE_BYTE;
                cnt       <= 8'd0;
            end else begin
                case (state)
                    ST_IDLE: if (start) state <= ST_CMD;
                    ST_CMD: if (ev) begin
                        reg_addr <= rec_data[6:0];
                        reg_wr   <= rec_data[RW_BIT];
                        reg_req  <= ~rec_data[RW_BIT];
                        state    <= rec_data[RW_BIT] ? ST_DATA : ST_RD_REQ;
                    end
                    ST_DATA: if (ev) begin
                        reg_req <= 1'b1;
                        if (reg_wr) begin
                            reg_wdata <= rec_data;
                            state     <= ST_WR_REQ;
                        end else begin
                            reg_addr <= next_addr(reg_addr);
                            state    <= ST_RD_REQ;
                        end
                    end
                    ST_RD_REQ, ST_WR_REQ: begin
                        // A new byte before the access finished means the master outran the bus.
                        if (ev) begin
                            err     <= 1'b1;
                            reg_req <= 1'b0;
                            cnt     <= 8'd0;
                            state   <= ST_DRAIN;
                        end else if (reg_ack) begin
                            reg_req <= 1'b0;
                            cnt     <= 8'd0;
                            state   <= ST_DATA;
                            if (state == ST_RD_REQ)
                                send_data <= reg_rdata;
                            else
                                reg_addr <= next_addr(reg_addr);
                        end else if (cnt == ACK_LAST) begin
                            err       <= 1'b1;
                            send_data <= SPI_ERR_BYTE;
                            reg_req   <= 1'b0;
                            cnt       <= 8'd0;
                            state     <= ST_DRAIN;
                        end else begin
                            cnt <= cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 Parameter: DELAY, 2, simulation-only non-blocking assignment delay on every register.
REQ-002 Parameter: ACK_TO, 15, maximum clk cycles to wait for reg_ack before timing out (range 1..255).
REQ-003 Ports, in order:
- clk in 1: single clock.
- rst in 1: reset; one clock, reset is synchronous and active-high.
- ncs in 1: raw SPI chip select from the pin, active low, may glitch.
- rec_flag in 1: byte-received flag from the SPI byte slave, multi-cycle high pulse.
- rec_data in 8: received byte, valid while rec_flag is high.
- send_data out 8: byte the SPI slave shifts out on the next byte.
- reg_req out 1: register access request.
- reg_wr out 1: 1 = write, 0 = read; valid with reg_req.
- reg_addr out 7: register address.
- reg_wdata out 8: write data.
- reg_rdata in 8: read data, valid with reg_ack.
- reg_ack in 1: one-cycle acknowledge.
- err out 1: sticky timeout flag.

Function
REQ-004 ncs SHALL pass through a 3-stage synchronizer; frame end = all three samples 1; frame start = all three samples 0.
REQ-005 A byte event SHALL be the rising edge of rec_flag (registered previous value); remaining high cycles SHALL be ignored.
REQ-006 Frame format: byte0 = {rw, addr[6:0]} (rw=1 write); each following byte is a data byte.
REQ-007 States SHALL be IDLE, CMD, RD_REQ, WR_REQ, DATA, DRAIN.
- IDLE: on frame start -> CMD.
- CMD: on byte event, latch addr and rw; read -> RD_REQ, write -> DATA.
- DATA: on byte event, read frame -> advance address, then RD_REQ (prefetch); write frame -> latch reg_wdata, then WR_REQ.
- RD_REQ / WR_REQ: hold reg_req until reg_ack or timeout; read -> DATA, write -> advance address, then DATA.
- DRAIN: wait for frame end -> IDLE.
REQ-008 reg_req, reg_wr, reg_addr and reg_wdata SHALL be stable from request assertion through the ack cycle; reg_req SHALL deassert the cycle after reg_ack.
REQ-009 On a read ack, send_data SHALL load reg_rdata in the ack cycle and hold it until the next load.
REQ-010 Timeout: the counter reaching ACK_TO without ack SHALL set err, load send_data = 8'hEE, drop reg_req and go to DRAIN.
REQ-011 Frame end in any state other than IDLE SHALL abort and return to IDLE next cycle:
- reg_req dropped.
- A pending write discarded.
- send_data = 8'h00.
REQ-012 A byte event while in RD_REQ or WR_REQ (master too fast) SHALL set err and go to DRAIN.
REQ-013 Address advance SHALL be +1 modulo 128 (7'h7F wraps to 7'h00).
REQ-014 err SHALL clear on frame start; otherwise it is sticky.
REQ-015 The SPI clock period SHALL be at least 2*(ACK_TO+8) clk cycles; this is a system constraint.

Reset
REQ-016 With rst high at a clk edge:
- State -> IDLE.
- send_data = 8'h00, reg_req = 0, reg_wr = 0, reg_addr = 0, reg_wdata = 0, err = 0.
- Synchronizer = 3'b111; rec_flag history = 0; timeout counter = 0.
REQ-017 Reset mid-access SHALL drop reg_req in the same edge with no further bus activity.

Configuration
REQ-018 Macro SPI_REG_CTRL_AUTOINC_EN:
- Defined: address advance per REQ-013.
- Undefined: address stays fixed for the whole frame (repeated access to one register).

Structure
REQ-019 Shared package/header spi_pkg SHALL hold:
- State encodings.
- Constants: SPI_ERR_BYTE = 8'hEE, SPI_IDLE_BYTE = 8'h00, RW bit index 7.
REQ-020 One sub-module, spi_ncs_sync, SHALL implement the 3-stage ncs synchronizer with start/end decode; it is reused by other SPI blocks.

Verification
REQ-021 Write burst: frame 8'h85, 8'hA1, 8'hB2, ack after 2 cycles -> writes addr 0x05 = 0xA1 and addr 0x06 = 0xB2; err = 0.
REQ-022 Read burst: frame 8'h10 plus 2 dummy bytes, rdata = addr+0x40 -> send_data = 0x50 then 0x51; reads issued at 0x10 and 0x11.
REQ-023 Wrap: write starting at 8'hFF with 2 data bytes -> addresses 0x7F then 0x00; with macro undefined -> 0x7F twice.
REQ-024 Timeout: read with reg_ack never asserted -> reg_req drops after 15 cycles, err = 1, send_data = 0xEE; next frame start clears err.
REQ-025 Abort: ncs high for 3 cycles mid-WR_REQ -> reg_req drops; state returns to IDLE; a 2-cycle ncs glitch causes no abort.
REQ-026 Reset: rst asserted during RD_REQ -> all outputs at reset values on the next edge; no reg_ack is consumed afterwards.
